trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 124 ++++++++++++
 tb/tb_trace_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// Retirement trace buffer: first-word-fall-through FIFO of {pc, inst, wbdata}
// with drop counting and a stop-address triggered capture shutdown.
module trace_buffer #(
    parameter int DEPTH    = 8,
    parameter int STOPWORD = 11
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       retire,
    input  logic [31:0]                pc,
    input  logic [31:0]                inst,
    input  logic [31:0]                wbdata,
    input  logic                       ready,
    output logic                       valid,
    output logic [31:0]                tpc,
    output logic [31:0]                tinst,
    output logic [31:0]                tdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                dropped,
    output logic                       halted,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STOP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [15:0]     r_dropped;

    logic [31:0]     r_mem_pc   [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];

    logic            w_run;
    logic            w_full;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_stop_hit;

    assign w_run      = (r_state == RUN);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && ready;
    assign w_push     = retire && w_run && (!w_full || w_pop);
    assign w_drop     = retire && w_run && w_full && !w_pop;
    assign w_stop_hit = retire && w_run && (pc[31:2] == 30'(STOPWORD));

    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Record storage; contents need no reset because valid masks stale slots.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_pc[r_wptr]   <= pc;
            r_mem_inst[r_wptr] <= inst;
            r_mem_data[r_wptr] <= wbdata;
        end
    end

    // Pointers, occupancy and saturating drop counter.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    // Capture state register.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next capture state; DONE is entered as soon as the post-edge count is zero.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_stop_hit) begin
                    w_state_next = (w_count_next == '0) ? DONE : STOP;
                end
            end
            STOP: begin
                if (w_count_next == '0) w_state_next = DONE;
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = RUN;
        endcase
    end

    assign valid   = w_valid;
    assign tpc     = w_valid ? r_mem_pc[r_rptr]   : 32'd0;
    assign tinst   = w_valid ? r_mem_inst[r_rptr] : 32'd0;
    assign tdata   = w_valid ? r_mem_data[r_rptr] : 32'd0;
    assign count   = r_count;
    assign dropped = r_dropped;
    assign halted  = (r_state != RUN);
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: vector table plus a long drop-saturation run.
// Inputs change just after a rising edge; outputs are checked 1ns after each edge.
module tb_trace_buffer;

    logic        clock = 1'b0;
    logic        nreset;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wbdata;
    logic        ready;
    logic        valid;
    logic [31:0] tpc;
    logic [31:0] tinst;
    logic [31:0] tdata;
    logic [3:0]  count;
    logic [15:0] dropped;
    logic        halted;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        nrst;
        logic        ret;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic [31:0] etpc;
        logic [31:0] etinst;
        logic [31:0] etdata;
        logic [3:0]  ecnt;
        logic [15:0] edrop;
        logic        ehalt;
        logic        edone;
    } vec_t;

    vec_t vecs[$];

    trace_buffer #(.DEPTH(8), .STOPWORD(11)) dut (
        .clock   (clock),
        .nreset  (nreset),
        .retire  (retire),
        .pc      (pc),
        .inst    (inst),
        .wbdata  (wbdata),
        .ready   (ready),
        .valid   (valid),
        .tpc     (tpc),
        .tinst   (tinst),
        .tdata   (tdata),
        .count   (count),
        .dropped (dropped),
        .halted  (halted),
        .done    (done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a == 32'd0) ? 32'h00100093 : (32'hA000_0000 | a);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'd0) ? 32'd1 : (32'hD000_0000 | a);
    endfunction

    task automatic add(input logic nrst, input logic ret, input logic [31:0] p,
                       input logic rdy, input logic ev, input logic [31:0] etpc,
                       input int ecnt, input int edrop,
                       input logic ehalt, input logic edone);
        vec_t v;
        v.nrst   = nrst;
        v.ret    = ret;
        v.pc     = p;
        v.rdy    = rdy;
        v.ev     = ev;
        v.etpc   = ev ? etpc : 32'd0;
        v.etinst = ev ? inst_of(etpc) : 32'd0;
        v.etdata = ev ? data_of(etpc) : 32'd0;
        v.ecnt   = 4'(ecnt);
        v.edrop  = 16'(edrop);
        v.ehalt  = ehalt;
        v.edone  = edone;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic nrst, input logic ret,
                         input logic [31:0] p, input logic rdy);
        nreset = nrst;
        retire = ret;
        pc     = p;
        inst   = inst_of(p);
        wbdata = data_of(p);
        ready  = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input vec_t v);
        checks++;
        if (valid !== v.ev || tpc !== v.etpc || tinst !== v.etinst ||
            tdata !== v.etdata || count !== v.ecnt || dropped !== v.edrop ||
            halted !== v.ehalt || done !== v.edone) begin
            errors++;
            $display("FAIL %s: got v=%b pc=%h in=%h d=%h c=%0d dr=%0d h=%b dn=%b, want v=%b pc=%h in=%h d=%h c=%0d dr=%0d h=%b dn=%b",
                     name, valid, tpc, tinst, tdata, count, dropped, halted, done,
                     v.ev, v.etpc, v.etinst, v.etdata, v.ecnt, v.edrop, v.ehalt, v.edone);
        end
    endtask

    initial begin
        vec_t v;
        nreset = 1'b0;
        retire = 1'b0;
        pc     = '0;
        inst   = '0;
        wbdata = '0;
        ready  = 1'b0;

        // Reset with a retire present: not captured.
        add(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        // First record visible next cycle.
        add(1, 1, 32'd0, 0, 1, 32'd0, 1, 0, 0, 0);
        for (int i = 1; i < 8; i++) add(1, 1, 32'(4 * i), 0, 1, 32'd0, i + 1, 0, 0, 0);
        // Ninth record dropped.
        add(1, 1, 32'd32, 0, 1, 32'd0, 8, 1, 0, 0);
        // Full with push and pop together.
        add(1, 1, 32'd36, 1, 1, 32'd4, 8, 1, 0, 0);
        for (int i = 1; i <= 6; i++) add(1, 0, 32'd0, 1, 1, 32'(4 + 4 * i), 8 - i, 1, 0, 0);
        add(1, 0, 32'd0, 1, 1, 32'd36, 1, 1, 0, 0);
        add(1, 0, 32'd0, 1, 0, 32'd0, 0, 1, 0, 0);
        // Stop pc, pushed while empty with ready high.
        add(1, 1, 32'd44, 1, 1, 32'd44, 1, 1, 1, 0);
        add(1, 1, 32'd48, 0, 1, 32'd44, 1, 1, 1, 0);
        add(1, 0, 32'd0, 1, 0, 32'd0, 0, 1, 1, 1);
        add(1, 1, 32'd52, 1, 0, 32'd0, 0, 1, 1, 1);
        // Reset mid-operation from a full buffer with drops.
        add(0, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 32'(32'h100 + 4 * i), 0, 1, 32'h100, i + 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 32'(32'h120 + 4 * i), 0, 1, 32'h100, 8, i + 1, 0, 0);
        add(0, 1, 32'h134, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 32'h140, 0, 1, 32'h140, 1, 0, 0, 0);
        // Stop record dropped on a full buffer, then drain to done.
        for (int i = 1; i < 8; i++) add(1, 1, 32'(32'h140 + 4 * i), 0, 1, 32'h140, i + 1, 0, 0, 0);
        add(1, 1, 32'd44, 0, 1, 32'h140, 8, 1, 1, 0);
        add(1, 1, 32'h15C, 0, 1, 32'h140, 8, 1, 1, 0);
        for (int i = 1; i < 8; i++) add(1, 1, 32'h160, 1, 1, 32'(32'h140 + 4 * i), 8 - i, 1, 1, 0);
        add(1, 1, 32'h160, 1, 0, 0, 0, 1, 1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].nrst, vecs[i].ret, vecs[i].pc, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i]);
        end

        // Drop counter saturation.
        drive(0, 0, 32'd0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 32'(32'h200 + 4 * i), 0);
        for (int i = 0; i < 65534; i++) drive(1, 1, 32'h300, 0);
        v = '{nrst: 1, ret: 1, pc: 32'h300, rdy: 0, ev: 1, etpc: 32'h200,
              etinst: inst_of(32'h200), etdata: data_of(32'h200),
              ecnt: 4'd8, edrop: 16'hFFFE, ehalt: 0, edone: 0};
        check("sat_fffe", v);
        for (int i = 0; i < 6; i++) drive(1, 1, 32'h300, 0);
        v.edrop = 16'hFFFF;
        check("sat_ffff", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
